// File: rtl/fake_signal_checker.sv
// Receive-side checker for the fake-signal injector: tracks ramp lock, pulse width/interval and error counts.
// Optional macro FAKE_CHECK_LG_EN also checks the low-gain half of the packed ADC word.
module fake_signal_checker #(
    parameter int PEDESTAL     = 200,
    parameter int SIGNAL_BINS  = 1847,
    parameter int SIGNAL_WIDTH = 30,
    parameter int THRESH       = 100,
    parameter int LOCK_COUNT   = 4,
    parameter int CNT_BITS     = 32
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                ENABLE,
    input  logic [4:0]          MODE,
    input  logic                CLR_COUNTS,
    input  logic [23:0]         ADC_IN,
    output logic [CNT_BITS-1:0] PULSE_COUNT,
    output logic [15:0]         ERR_COUNT,
    output logic [11:0]         LAST_WIDTH,
    output logic [CNT_BITS-1:0] LAST_INTERVAL,
    output logic                RAMP_LOCKED,
    output logic                ERR_PULSE
);

    localparam int          RUN_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [11:0] PED_L    = 12'(PEDESTAL);
    localparam logic [11:0] BINS_L   = 12'(SIGNAL_BINS);
    localparam logic [11:0] SIG_W_L  = 12'(SIGNAL_WIDTH);
    localparam logic [11:0] THRESH_L = 12'(THRESH);
    localparam logic [11:0] SIG_LG_L = 12'((SIGNAL_BINS >> 5) + PEDESTAL);
    localparam logic [RUN_W-1:0] LOCK_L = RUN_W'(LOCK_COUNT);

    typedef enum logic { R_UNLOCKED = 1'b0, R_LOCKED = 1'b1 } ramp_state_t;
    typedef enum logic { P_IDLE = 1'b0, P_HIGH = 1'b1 } pulse_state_t;
    typedef enum logic [1:0] { M_RESET = 2'd0, M_RAMP = 2'd1, M_PULSE = 2'd2 } mode_class_t;

    function automatic logic [CNT_BITS-1:0] sat_inc_cnt(input logic [CNT_BITS-1:0] v);
        if (&v) return v;
        else    return v + CNT_BITS'(1);
    endfunction

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        if (&v) return v;
        else    return v + 12'd1;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, v} + {15'd0, inc};
        if (sum[16]) return 16'hFFFF;
        else         return sum[15:0];
    endfunction

    logic [11:0]         hg_r, lg_r, p_prev_r, width_r;
    logic [RUN_W-1:0]    run_r;
    logic [CNT_BITS-1:0] interval_r, pulse_cnt_r, last_int_r;
    logic [15:0]         err_cnt_r;
    logic [11:0]         last_width_r;
    logic                first_r, perr_r, ramp_locked_r, err_pulse_r;
    ramp_state_t         ramp_st_r;
    pulse_state_t        pulse_st_r;
    mode_class_t         cls_r, cls_s;

    logic [11:0] p_s, p_exp_s;
    logic        soft_rst_s, active_s, ramp_good_s, pulse_hi_s, rise_s;
    logic        base_err_s, amp_err_s, rise_evt_s, fall_evt_s;
    logic        lg_ramp_ok_s, lg_base_ok_s, lg_high_ok_s;
    logic [1:0]  err_inc_s;

    // Stage-1 checks: classify the registered sample and decide this cycle's events and error count.
    always_comb begin
        p_s     = hg_r - PED_L;
        p_exp_s = (p_prev_r + 12'd1) & 12'h7FF;
        if (MODE == 5'd0)      cls_s = M_RESET;
        else if (MODE == 5'd6) cls_s = M_RAMP;
        else                   cls_s = M_PULSE;
        // Entering a different mode family restarts both FSMs without judging the stale sample.
        soft_rst_s = (cls_s == M_RESET) || (cls_s != cls_r);
        active_s   = ENABLE && !soft_rst_s;
`ifdef FAKE_CHECK_LG_EN
        lg_ramp_ok_s = (lg_r == ((p_s >> 5) + PED_L));
        lg_base_ok_s = (lg_r == PED_L);
        lg_high_ok_s = (lg_r == SIG_LG_L);
`else
        // LG is captured but never gates a check in this build.
        lg_ramp_ok_s = 1'b1 | (^lg_r);
        lg_base_ok_s = 1'b1;
        lg_high_ok_s = 1'b1;
`endif
        ramp_good_s = (p_s == p_exp_s) && (hg_r >= PED_L) && lg_ramp_ok_s;
        pulse_hi_s  = (p_s >= THRESH_L);
        rise_s      = pulse_hi_s && !p_s[11];
        base_err_s  = (hg_r != PED_L) || !lg_base_ok_s;
        amp_err_s   = (p_s != BINS_L) || !lg_high_ok_s;
        rise_evt_s  = 1'b0;
        fall_evt_s  = 1'b0;
        err_inc_s   = 2'd0;
        if (active_s && (cls_s == M_RAMP)) begin
            if ((ramp_st_r == R_LOCKED) && !ramp_good_s) err_inc_s = 2'd1;
            else                                         err_inc_s = 2'd0;
        end else if (active_s && (cls_s == M_PULSE)) begin
            case (pulse_st_r)
                P_IDLE: begin
                    if (rise_s)          rise_evt_s = 1'b1;
                    else if (base_err_s) err_inc_s  = 2'd1;
                    else                 err_inc_s  = 2'd0;
                end
                P_HIGH: begin
                    if (pulse_hi_s) begin
                        err_inc_s = 2'd0;
                    end else begin
                        fall_evt_s = 1'b1;
                        err_inc_s  = {1'b0, (width_r != SIG_W_L) || perr_r} + {1'b0, base_err_s};
                    end
                end
                default: err_inc_s = 2'd0;
            endcase
        end else begin
            err_inc_s = 2'd0;
        end
    end

    // Input capture, output counters and both FSMs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hg_r          <= 12'd0;
            lg_r          <= 12'd0;
            p_prev_r      <= 12'd0;
            width_r       <= 12'd0;
            run_r         <= '0;
            interval_r    <= '0;
            pulse_cnt_r   <= '0;
            last_int_r    <= '0;
            err_cnt_r     <= 16'd0;
            last_width_r  <= 12'd0;
            first_r       <= 1'b1;
            perr_r        <= 1'b0;
            ramp_locked_r <= 1'b0;
            err_pulse_r   <= 1'b0;
            ramp_st_r     <= R_UNLOCKED;
            pulse_st_r    <= P_IDLE;
            cls_r         <= M_RESET;
        end else begin
            hg_r        <= ADC_IN[23:12];
            lg_r        <= ADC_IN[11:0];
            err_pulse_r <= (err_inc_s != 2'd0);
            if (CLR_COUNTS) begin
                pulse_cnt_r  <= '0;
                err_cnt_r    <= 16'd0;
                last_width_r <= 12'd0;
                last_int_r   <= '0;
            end else begin
                err_cnt_r <= sat_add16(err_cnt_r, err_inc_s);
                if (fall_evt_s) begin
                    pulse_cnt_r  <= sat_inc_cnt(pulse_cnt_r);
                    last_width_r <= width_r;
                end
                if (rise_evt_s && !first_r) last_int_r <= sat_inc_cnt(interval_r);
            end
            if (ENABLE) begin
                cls_r    <= cls_s;
                p_prev_r <= p_s;
                if (soft_rst_s) begin
                    ramp_st_r     <= R_UNLOCKED;
                    ramp_locked_r <= 1'b0;
                    run_r         <= '0;
                    pulse_st_r    <= P_IDLE;
                    first_r       <= 1'b1;
                    perr_r        <= 1'b0;
                    width_r       <= 12'd0;
                    interval_r    <= '0;
                end else begin
                    if (rise_evt_s) interval_r <= '0;
                    else            interval_r <= sat_inc_cnt(interval_r);
                    if (cls_s == M_RAMP) begin
                        case (ramp_st_r)
                            R_UNLOCKED: begin
                                if (!ramp_good_s) begin
                                    run_r <= '0;
                                end else if ((run_r + RUN_W'(1)) == LOCK_L) begin
                                    ramp_st_r     <= R_LOCKED;
                                    ramp_locked_r <= 1'b1;
                                    run_r         <= '0;
                                end else begin
                                    run_r <= run_r + RUN_W'(1);
                                end
                            end
                            R_LOCKED: begin
                                if (!ramp_good_s) begin
                                    ramp_st_r     <= R_UNLOCKED;
                                    ramp_locked_r <= 1'b0;
                                    run_r         <= '0;
                                end
                            end
                            default: ramp_st_r <= R_UNLOCKED;
                        endcase
                    end else begin
                        case (pulse_st_r)
                            P_IDLE: begin
                                if (rise_s) begin
                                    pulse_st_r <= P_HIGH;
                                    width_r    <= 12'd1;
                                    first_r    <= 1'b0;
                                    perr_r     <= 1'b0;
                                end
                            end
                            P_HIGH: begin
                                if (pulse_hi_s) begin
                                    width_r <= sat_inc12(width_r);
                                    if (amp_err_s) perr_r <= 1'b1;
                                end else begin
                                    pulse_st_r <= P_IDLE;
                                end
                            end
                            default: pulse_st_r <= P_IDLE;
                        endcase
                    end
                end
            end
        end
    end

    assign PULSE_COUNT   = pulse_cnt_r;
    assign ERR_COUNT     = err_cnt_r;
    assign LAST_WIDTH    = last_width_r;
    assign LAST_INTERVAL = last_int_r;
    assign RAMP_LOCKED   = ramp_locked_r;
    assign ERR_PULSE     = err_pulse_r;

endmodule

// File: doc/fake_signal_checker.md
Name: fake_signal_checker

Overview:
- Receive-side companion to the fake-signal injector. It sits on one ADC channel's output, downstream of the injector and ahead of the filter and trigger modules.
- Monitors the packed 24-bit word: HG in [23:12], LG in [11:0].
- Verifies that injected ramp data and square pulses arrive intact, and counts pulses and errors.
- Measures pulse width and the rising-edge-to-rising-edge interval for software readback over AXI registers.

Parameters:
PEDESTAL, 200, expected baseline in HG and LG
SIGNAL_BINS, 1847, expected pulse height above pedestal (HG)
SIGNAL_WIDTH, 30, expected pulse width in clocks
THRESH, 100, HG-above-pedestal level that defines "pulse high"
LOCK_COUNT, 4, consecutive good ramp samples needed to lock
CNT_BITS, 32, width of pulse and interval counters

Ports:
CLK  in  1  system clock (120 MHz)
RESET_N  in  1  asynchronous active-low reset
ENABLE  in  1  checker active; when low, state is held and counters freeze
MODE  in  5  same MODE value given to the injector: 0 = reset, 6 = ramp, others = pulse
CLR_COUNTS  in  1  synchronous clear of PULSE_COUNT, ERR_COUNT, LAST_WIDTH, LAST_INTERVAL
ADC_IN  in  24  packed ADC word {HG, LG}
PULSE_COUNT  out  CNT_BITS  completed pulses (saturating)
ERR_COUNT  out  16  detected errors (saturating)
LAST_WIDTH  out  12  width of the last completed pulse, in clocks
LAST_INTERVAL  out  CNT_BITS  clocks between the last two rising edges (saturating)
RAMP_LOCKED  out  1  ramp tracker is locked
ERR_PULSE  out  1  one-clock strobe per counted error

Behaviour:
- Reset (RESET_N low, asynchronous): all outputs and internal state go to 0, and both FSMs return to their initial state.
- Pipeline: ADC_IN is registered (stage 1). Checks are evaluated on stage 1. Counters and strobes update on the next edge, so total latency from sample to visible effect is 2 clocks.
- P is 12-bit: P = HG_reg - PEDESTAL. Arithmetic wraps modulo 4096.
- MODE==0 (synchronous soft reset):
  - FSMs return to UNLOCKED/IDLE; FIRST flag is set; interval counter is cleared.
  - Output counters are held, not cleared.
- CLR_COUNTS has priority over any same-cycle increment: counters end the cycle at 0. ERR_PULSE may still assert.
- Ramp FSM (MODE==6):
  - Ramp expectation: P_exp = (P_prev + 1) & 12'h7FF. A sample is "good" when P == P_exp and HG_reg >= PEDESTAL.
  - UNLOCKED: each good sample increments the run counter; a bad sample sets it to 0. P_prev <= P every sample. When the run reaches LOCK_COUNT, go to LOCKED and set RAMP_LOCKED=1.
  - LOCKED: a good sample stays in LOCKED. A bad sample increments ERR_COUNT, pulses ERR_PULSE, goes to UNLOCKED with run=0, and resyncs P_prev <= P.
  - Wrap 2047 -> 0 is good.
  - No errors are counted while UNLOCKED.
- Pulse FSM (MODE not 0 and not 6):
  - IDLE:
    - If P >= THRESH and P < 2048: rising edge. Go to HIGH and set width=1.
    - On that rising edge, if FIRST=0, LAST_INTERVAL <= interval counter + 1. Then clear FIRST, clear the interval counter, clear the pulse error flag.
    - Otherwise, if HG_reg != PEDESTAL, count one baseline error for this sample.
  - HIGH:
    - While P >= THRESH: width++ (saturating at 4095). If P != SIGNAL_BINS, set the pulse error flag.
    - On the falling edge: LAST_WIDTH <= width; PULSE_COUNT++. If width != SIGNAL_WIDTH or the pulse error flag is set, count exactly one error for the pulse. Return to IDLE.
    - The falling-edge sample is itself baseline-checked on the next IDLE cycle rule, starting with the sample that fell.
  - Interval counter: increments every enabled cycle and saturates at all ones.
- MODE change between 6 and a pulse mode: both FSMs return to their initial state on the first cycle of the new mode; no error is counted.
- ENABLE low: no FSM transitions, no counting, ERR_PULSE=0. Stage 1 still captures input.
- All counters saturate at all-ones; they never wrap.

Optional Feature:
FAKE_CHECK_LG_EN
- Defined:
  - Ramp mode: a sample is good only if it also satisfies LG_reg == (P >> 5) + PEDESTAL.
  - Pulse IDLE: also requires LG_reg == PEDESTAL.
  - Pulse HIGH: also requires LG_reg == (SIGNAL_BINS >> 5) + PEDESTAL (= 257); a mismatch sets the pulse error flag.
- Undefined: LG is ignored everywhere and only HG is checked.

Test Plan:
1. Reset, MODE=6, drive a clean ramp from P=0 for 3000 clocks -> RAMP_LOCKED=1 after 4 good samples; wrap at 2047 produces ERR_COUNT=0.
2. MODE=6 locked, skip one ramp value (P jumps 100 -> 102) -> ERR_COUNT=1, one ERR_PULSE two clocks later, RAMP_LOCKED drops and relocks after 4 samples.
3. MODE=1, pulses of HG=2047 for 30 clocks every 1200 clocks, baseline 200, repeated 5 times -> PULSE_COUNT=5, LAST_WIDTH=30, LAST_INTERVAL=1200, ERR_COUNT=0.
4. MODE=1, one pulse with width 29, then one pulse with amplitude 2046 for a single clock -> ERR_COUNT=2 (one per pulse), LAST_WIDTH=30.
5. Baseline glitch HG=201 for 3 idle clocks -> ERR_COUNT +3. Then assert CLR_COUNTS on the same cycle as a falling edge -> PULSE_COUNT=0.
6. RESET_N pulled low mid-pulse for 1 ns, asynchronously -> all outputs 0 immediately; the next full pulse gives PULSE_COUNT=1 and LAST_INTERVAL=0 (FIRST).
